sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares one single-port, 32-bit asynchronous SRAM between the instruction-fetch (IF) port and the MEM-stage load/store port.
- Sequences the SRAM strobes with a configurable wait-state count.
- Returns per-requester ack pulses; pipeline stall is derived as req & ~ack.
- Sits between the pipeline (IF/MEM stages and stall logic) and the top-level SRAM pins.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 1, extra cycles an access is held beyond the first (>=0).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  IF read request; held high until if_ack.
- if_addr  input  32  IF byte address; bits [ADDR_W+1:2] used.
- if_ack  output  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  output  32  fetched word.
- mem_req  input  1  MEM request; held high until mem_ack.
- mem_we  input  1  1=write, 0=read.
- mem_be  input  4  byte enables, active-high.
- mem_addr  input  32  byte address; bits [ADDR_W+1:2] used.
- mem_wdata  input  32  store data.
- mem_ack  output  1  one-cycle completion pulse.
- mem_rdata  output  32  load data, valid with mem_ack.
- if_stall  output  1  if_req & ~if_ack (combinational).
- mem_stall  output  1  mem_req & ~mem_ack (combinational).
- sram_addr  output  ADDR_W  SRAM word address.
- sram_wdata  output  32  data driven to pins.
- sram_data_oe  output  1  top-level tristate enable for sram_wdata.
- sram_rdata  input  32  data from pins.
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low strobes.
- sram_be_n  output  4  active-low byte enables.

Behaviour:
- Reset (synchronous) values:
  - State IDLE; wait counter 0; last_grant = IF.
  - ce_n, oe_n and we_n = 1; be_n = 4'hF; data_oe = 0.
  - sram_addr = 0; acks = 0; rdata registers = 0.
- Reset mid-access aborts the access: strobes go high on the next edge and no ack is issued.
- FSM states: IDLE, RD, WR, WR_HOLD, DONE.
- IDLE arbitration:
  - Both requests pending: grant MEM unless last_grant == MEM, in which case grant IF. This is round-robin and prevents IF starvation.
  - Only one pending: grant it.
  - On grant, latch requester id, address, we, be and wdata, and update last_grant.
  - Next state is RD (read) or WR (write); counter = 0.
- RD:
  - ce_n = 0, oe_n = 0, be_n = 0 (whole word).
  - Counter increments each cycle.
  - When counter == WAIT_CYCLES: capture sram_rdata into the granted requester's rdata register, then go to DONE.
- WR:
  - ce_n = 0, we_n = 0, be_n = ~mem_be, data_oe = 1.
  - Counter == WAIT_CYCLES -> WR_HOLD.
- WR_HOLD:
  - we_n = 1; ce_n = 0; addr, data and data_oe held.
  - Provides one cycle of data/address hold. Next state is DONE.
- DONE:
  - Granted requester's ack = 1 for exactly this cycle; all strobes high; data_oe = 0.
  - Next state is IDLE.
- Latency:
  - Read: req sampled in IDLE at cycle t; ack at t+WAIT_CYCLES+2.
  - Write: ack at t+WAIT_CYCLES+3.
- Request/address changes during an access are ignored, because the request is latched at grant.
- The requester drops or changes req on the cycle after its ack. IDLE re-samples the following cycle, so there is no double-grant.
- IF write is impossible; mem_be is ignored for reads.
- Address bits above ADDR_W+1 are discarded (wrap-around). Bits [1:0] are ignored.
- Non-granted rdata registers retain their previous value.

Decomposition:
- Shared package mips_mem_pkg:
  - state encoding (IDLE=0, RD=1, WR=2, WR_HOLD=3, DONE=4);
  - requester id constants (REQ_IF=0, REQ_MEM=1);
  - default ADDR_W and WAIT_CYCLES.
- Single module; no sub-module. The wait counter is inline, $clog2(WAIT_CYCLES+1) bits, minimum 1.

Test Plan:
- IF read alone:
  - Stimulus: WAIT_CYCLES=1, if_req=1, if_addr=0x0000_0010, sram_rdata=0xDEADBEEF.
  - Response: sram_addr=4; oe_n low for 2 cycles; if_ack pulses 3 cycles after sampling; if_rdata=0xDEADBEEF; if_stall low only in the ack cycle.
- MEM byte write:
  - Stimulus: mem_we=1, mem_be=4'b0010, mem_addr=0x20, mem_wdata=0x0000AB00.
  - Response: we_n low 2 cycles, then WR_HOLD with we_n=1 and data_oe=1; be_n=4'b1101; mem_ack 4 cycles after sampling.
- Simultaneous requests:
  - Stimulus: if_req and mem_req rise together after reset.
  - Response: MEM is served first, then IF. A repeated simultaneous pair then alternates the grant: IF, then MEM.
- Back-to-back IF with pending MEM:
  - Stimulus: if_req held continuously, mem_req asserted mid-IF access.
  - Response: MEM is granted in the next IDLE, and IF is not starved.
- Reset mid-read:
  - Stimulus: reset asserted during RD.
  - Response: the next cycle shows all strobes high, be_n=4'hF, no ack, state IDLE; the request is then re-served from the start.
- WAIT_CYCLES=0:
  - Stimulus: same as the first read scenario.
  - Response: read ack at t+2 and write ack at t+3; rdata correct.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS memory subsystem: SRAM arbiter FSM encoding,
// requester ids and the latched-access record.
package mips_mem_pkg;

   localparam int DEF_ADDR_W      = 20;
   localparam int DEF_WAIT_CYCLES = 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD      = 3'd1;
   localparam logic [2:0] ST_WR      = 3'd2;
   localparam logic [2:0] ST_WR_HOLD = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic REQ_IF  = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   typedef struct packed {
      logic        id;
      logic [3:0]  be;
      logic [31:0] wdata;
   } acc_t;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous single-port SRAM between the IF and MEM ports,
// sequencing registered strobes with WAIT_CYCLES extra cycles per access.
module sram_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_be,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_ack,
   output logic [31:0]       mem_rdata,
   output logic              if_stall,
   output logic              mem_stall,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   output logic              sram_data_oe,
   input  logic [31:0]       sram_rdata,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   acc_t              acc_q, acc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic [3:0]        be_n_q, be_n_d;
   logic              data_oe_q, data_oe_d;
   logic              if_ack_q, if_ack_d;
   logic              mem_ack_q, mem_ack_d;
   logic              grant_mem;

   // Byte-lane and above-window address bits are discarded by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr >> (ADDR_W + 2), if_addr[1:0],
                               mem_addr >> (ADDR_W + 2), mem_addr[1:0]};

   // NOTE: every combinational output is given a default first so no path
   // through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      acc_d        = acc_q;
      addr_d       = addr_q;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;
      grant_mem    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (if_req || mem_req) begin
               // Round-robin on a tie: MEM wins unless it won last time.
               grant_mem = mem_req && (!if_req || (last_grant_q != REQ_MEM));
               if (grant_mem) begin
                  acc_d   = '{id: REQ_MEM, be: mem_be, wdata: mem_wdata};
                  addr_d  = mem_addr[ADDR_W+1:2];
                  state_d = mem_we ? ST_WR : ST_RD;
               end else begin
                  acc_d   = '{id: REQ_IF, be: 4'h0, wdata: 32'h0};
                  addr_d  = if_addr[ADDR_W+1:2];
                  state_d = ST_RD;
               end
               last_grant_d = acc_d.id;
               cnt_d        = '0;
            end
         end
         ST_RD: begin
            if (cnt_q == CNT_LAST) begin
               if (acc_q.id == REQ_MEM) mem_rdata_d = sram_rdata;
               else                     if_rdata_d  = sram_rdata;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WR: begin
            if (cnt_q == CNT_LAST) state_d = ST_WR_HOLD;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_WR_HOLD: state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Pin strobes are registered from the next state so they change
      // cleanly on the clock edge that enters each phase.
      ce_n_d    = !((state_d == ST_RD) || (state_d == ST_WR) || (state_d == ST_WR_HOLD));
      oe_n_d    = (state_d != ST_RD);
      we_n_d    = (state_d != ST_WR);
      data_oe_d = (state_d == ST_WR) || (state_d == ST_WR_HOLD);
      if (state_d == ST_RD)
         be_n_d = 4'h0;
      else if (data_oe_d)
         be_n_d = ~acc_d.be;
      else
         be_n_d = 4'hF;
      if_ack_d  = (state_d == ST_DONE) && (acc_d.id == REQ_IF);
      mem_ack_d = (state_d == ST_DONE) && (acc_d.id == REQ_MEM);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= REQ_IF;
         acc_q        <= '0;
         addr_q       <= '0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         be_n_q       <= 4'hF;
         data_oe_q    <= 1'b0;
         if_ack_q     <= 1'b0;
         mem_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         acc_q        <= acc_d;
         addr_q       <= addr_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         be_n_q       <= be_n_d;
         data_oe_q    <= data_oe_d;
         if_ack_q     <= if_ack_d;
         mem_ack_q    <= mem_ack_d;
      end
   end

   assign if_ack       = if_ack_q;
   assign mem_ack      = mem_ack_q;
   assign if_rdata     = if_rdata_q;
   assign mem_rdata    = mem_rdata_q;
   assign if_stall     = if_req & ~if_ack_q;
   assign mem_stall    = mem_req & ~mem_ack_q;
   assign sram_addr    = addr_q;
   assign sram_wdata   = acc_q.wdata;
   assign sram_data_oe = data_oe_q;
   assign sram_ce_n    = ce_n_q;
   assign sram_oe_n    = oe_n_q;
   assign sram_we_n    = we_n_q;
   assign sram_be_n    = be_n_q;

endmodule
